sha256_msg_arbiter: RTL and testbench

//  Shares one sha256_message_build instance between NUM_CH requesters. Each requester offers a
//  cfg beat (size/scheme/last) followed by a data packet of 512-bit beats ending in data_last.

---
 rtl/sha256_msg_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sha256_msg_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_arbiter.sv
// rtl/sha256_msg_arbiter.sv - round-robin packet arbiter sharing one SHA-256 message builder
// Grants are held for a full cfg+data packet; an ID FIFO tags the builder's output blocks.
module sha256_msg_arbiter #(
    parameter int NUM_CH   = 4,
    parameter int ID_W     = 2,
    parameter int ID_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  sync_rst,
    input  logic [NUM_CH*64-1:0]  ch_cfg_size,
    input  logic [NUM_CH*2-1:0]   ch_cfg_scheme,
    input  logic [NUM_CH-1:0]     ch_cfg_last,
    input  logic [NUM_CH-1:0]     ch_cfg_valid,
    output logic [NUM_CH-1:0]     ch_cfg_ready,
    input  logic [NUM_CH*512-1:0] ch_data,
    input  logic [NUM_CH-1:0]     ch_data_last,
    input  logic [NUM_CH-1:0]     ch_data_valid,
    output logic [NUM_CH-1:0]     ch_data_ready,
    output logic [63:0]           mb_cfg_size,
    output logic [1:0]            mb_cfg_scheme,
    output logic                  mb_cfg_last,
    output logic                  mb_cfg_valid,
    input  logic                  mb_cfg_ready,
    output logic [511:0]          mb_data_in,
    output logic                  mb_data_in_last,
    output logic                  mb_data_in_valid,
    input  logic                  mb_data_in_ready,
    input  logic [511:0]          mb_data_out,
    input  logic                  mb_data_out_last,
    input  logic                  mb_data_out_valid,
    output logic                  mb_data_out_ready,
    output logic [511:0]          out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ID_W-1:0]       out_id,
    output logic                  id_underflow
);

    localparam int PTR_W = $clog2(ID_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CFG  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   next_grant;
    logic              next_found;
    logic [ID_W-1:0]   id_mem [ID_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              data_hs;
    logic [ID_W-1:0]   grant_inc;
    int                gi;

    assign gi = int'(grant);

    // Descending scan so the channel closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        next_found = 1'b0;
        next_grant = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ch_cfg_valid[(int'(rr_ptr) + k) % NUM_CH]) begin
                next_found = 1'b1;
                next_grant = ID_W'((int'(rr_ptr) + k) % NUM_CH);
            end
        end
    end

    always_comb begin
        mb_cfg_size      = '0;
        mb_cfg_scheme    = '0;
        mb_cfg_last      = 1'b0;
        mb_cfg_valid     = 1'b0;
        mb_data_in       = '0;
        mb_data_in_last  = 1'b0;
        mb_data_in_valid = 1'b0;
        ch_cfg_ready     = '0;
        ch_data_ready    = '0;
        if (state == S_CFG) begin
            mb_cfg_size      = ch_cfg_size[gi*64 +: 64];
            mb_cfg_scheme    = ch_cfg_scheme[gi*2 +: 2];
            mb_cfg_last      = ch_cfg_last[gi];
            mb_cfg_valid     = en && ch_cfg_valid[gi];
            ch_cfg_ready[gi] = en && mb_cfg_ready;
        end
        if (state == S_DATA) begin
            mb_data_in        = ch_data[gi*512 +: 512];
            mb_data_in_last   = ch_data_last[gi];
            mb_data_in_valid  = en && ch_data_valid[gi];
            ch_data_ready[gi] = en && mb_data_in_ready;
        end
    end

    assign push      = mb_cfg_valid && mb_cfg_ready;
    assign data_hs   = mb_data_in_valid && mb_data_in_ready;
    assign grant_inc = (gi == NUM_CH - 1) ? '0 : grant + ID_W'(1);

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // Builder output is forwarded only while an owner ID is known.
    assign out_data          = mb_data_out;
    assign out_last          = mb_data_out_last;
    assign out_valid         = en && mb_data_out_valid && !fifo_empty;
    assign mb_data_out_ready = en && out_ready && !fifo_empty;
    assign out_id            = fifo_empty ? '0 : id_mem[rd_ptr[PTR_W-1:0]];
    assign pop               = out_valid && out_ready && out_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            grant        <= '0;
            rr_ptr       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            id_underflow <= 1'b0;
            for (int i = 0; i < ID_DEPTH; i++) id_mem[i] <= '0;
        end else if (sync_rst) begin
            state        <= S_IDLE;
            grant        <= '0;
            rr_ptr       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            id_underflow <= 1'b0;
            for (int i = 0; i < ID_DEPTH; i++) id_mem[i] <= '0;
        end else begin
            if (mb_data_out_valid && fifo_empty) id_underflow <= 1'b1;
            if (push) begin
                id_mem[wr_ptr[PTR_W-1:0]] <= grant;
                wr_ptr                    <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            if (en) begin
                case (state)
                    S_IDLE: begin
                        if (!fifo_full && next_found) begin
                            grant <= next_grant;
                            state <= S_CFG;
                        end
                    end
                    S_CFG: begin
                        if (push) state <= S_DATA;
                    end
                    S_DATA: begin
                        if (data_hs && mb_data_in_last) begin
                            rr_ptr <= grant_inc;
                            state  <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_arbiter.sv
// tb/tb_sha256_msg_arbiter.sv - randomized scoreboard bench for sha256_msg_arbiter
module tb_sha256_msg_arbiter;

    localparam int NUM_CH   = 4;
    localparam int ID_W     = 2;
    localparam int ID_DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rst, en, sync_rst;
    logic [NUM_CH*64-1:0]  ch_cfg_size;
    logic [NUM_CH*2-1:0]   ch_cfg_scheme;
    logic [NUM_CH-1:0]     ch_cfg_last, ch_cfg_valid, ch_cfg_ready;
    logic [NUM_CH*512-1:0] ch_data;
    logic [NUM_CH-1:0]     ch_data_last, ch_data_valid, ch_data_ready;
    logic [63:0]           mb_cfg_size;
    logic [1:0]            mb_cfg_scheme;
    logic                  mb_cfg_last, mb_cfg_valid, mb_cfg_ready;
    logic [511:0]          mb_data_in;
    logic                  mb_data_in_last, mb_data_in_valid, mb_data_in_ready;
    logic [511:0]          mb_data_out;
    logic                  mb_data_out_last, mb_data_out_valid, mb_data_out_ready;
    logic [511:0]          out_data;
    logic                  out_last, out_valid, out_ready;
    logic [ID_W-1:0]       out_id;
    logic                  id_underflow;

    int checks = 0;
    int errors = 0;

    logic [511:0] beat_mem [NUM_CH][32];
    bit           blast_mem[NUM_CH][32];
    int           head[NUM_CH];
    int           pkts_left[NUM_CH];
    bit           phase[NUM_CH];
    bit           dv_held[NUM_CH];
    int           id_q[$];
    int           grant_log[$];

    always #5 clk = ~clk;

    sha256_msg_arbiter #(.NUM_CH(NUM_CH), .ID_W(ID_W), .ID_DEPTH(ID_DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .sync_rst(sync_rst),
        .ch_cfg_size(ch_cfg_size), .ch_cfg_scheme(ch_cfg_scheme), .ch_cfg_last(ch_cfg_last),
        .ch_cfg_valid(ch_cfg_valid), .ch_cfg_ready(ch_cfg_ready),
        .ch_data(ch_data), .ch_data_last(ch_data_last), .ch_data_valid(ch_data_valid),
        .ch_data_ready(ch_data_ready),
        .mb_cfg_size(mb_cfg_size), .mb_cfg_scheme(mb_cfg_scheme), .mb_cfg_last(mb_cfg_last),
        .mb_cfg_valid(mb_cfg_valid), .mb_cfg_ready(mb_cfg_ready),
        .mb_data_in(mb_data_in), .mb_data_in_last(mb_data_in_last),
        .mb_data_in_valid(mb_data_in_valid), .mb_data_in_ready(mb_data_in_ready),
        .mb_data_out(mb_data_out), .mb_data_out_last(mb_data_out_last),
        .mb_data_out_valid(mb_data_out_valid), .mb_data_out_ready(mb_data_out_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .id_underflow(id_underflow)
    );

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clear_inputs();
        en = 1'b1; sync_rst = 1'b0;
        ch_cfg_size = '0; ch_cfg_scheme = '0; ch_cfg_last = '0; ch_cfg_valid = '0;
        ch_data = '0; ch_data_last = '0; ch_data_valid = '0;
        mb_cfg_ready = 1'b0; mb_data_in_ready = 1'b0;
        mb_data_out = '0; mb_data_out_last = 1'b0; mb_data_out_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        ch_cfg_valid = '1; ch_data_valid = '1; mb_cfg_ready = 1'b1;
        mb_data_in_ready = 1'b1; out_ready = 1'b1;
        #3;
        checks++;
        if ({ch_cfg_ready, ch_data_ready, mb_cfg_valid, mb_data_in_valid, out_valid,
             mb_data_out_ready, out_id, id_underflow} !== '0 || mb_cfg_size !== 64'd0 ||
            mb_data_in !== 512'd0) begin
            errors++;
            $display("FAIL reset_outputs: cfg_rdy=%b data_rdy=%b mb_cfg_v=%b mb_din_v=%b out_v=%b out_id=%0d uf=%b, all required 0",
                     ch_cfg_ready, ch_data_ready, mb_cfg_valid, mb_data_in_valid, out_valid, out_id, id_underflow);
        end
        next_cycle();
        clear_inputs();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_single();
        logic [511:0] b0, b1, blk;
        b0 = rand512(); b1 = rand512(); blk = rand512();
        do_reset();
        ch_cfg_valid = 4'b0001; ch_cfg_size[63:0] = 64'd512; ch_cfg_scheme[1:0] = 2'd1;
        ch_cfg_last[0] = 1'b1; mb_cfg_ready = 1'b1;
        #4; checks++;
        if (mb_cfg_valid !== 1'b0) begin
            errors++; $display("FAIL single_arb_cycle: mb_cfg_valid=%b required 0", mb_cfg_valid);
        end
        next_cycle(); #4; checks++;
        if (mb_cfg_valid !== 1'b1 || mb_cfg_size !== 64'd512 || mb_cfg_scheme !== 2'd1 || ch_cfg_ready !== 4'b0001) begin
            errors++; $display("FAIL single_cfg: valid=%b size=%0d scheme=%0d ready=%b required 1/512/1/0001",
                               mb_cfg_valid, mb_cfg_size, mb_cfg_scheme, ch_cfg_ready);
        end
        next_cycle();
        ch_cfg_valid = '0; ch_data_valid = 4'b0001; ch_data[511:0] = b0; ch_data_last[0] = 1'b0;
        mb_data_in_ready = 1'b1;
        #4; checks++;
        if (mb_data_in_valid !== 1'b1 || mb_data_in !== b0 || mb_data_in_last !== 1'b0 || ch_data_ready !== 4'b0001) begin
            errors++; $display("FAIL single_beat0: valid=%b last=%b ready=%b data_ok=%b required 1/0/0001/1",
                               mb_data_in_valid, mb_data_in_last, ch_data_ready, mb_data_in === b0);
        end
        next_cycle();
        ch_data[511:0] = b1; ch_data_last[0] = 1'b1;
        #4; checks++;
        if (mb_data_in_valid !== 1'b1 || mb_data_in !== b1 || mb_data_in_last !== 1'b1) begin
            errors++; $display("FAIL single_beat1: valid=%b last=%b data_ok=%b required 1/1/1",
                               mb_data_in_valid, mb_data_in_last, mb_data_in === b1);
        end
        next_cycle();
        ch_data_valid = '0; ch_data_last = '0;
        mb_data_out_valid = 1'b1; mb_data_out = blk; mb_data_out_last = 1'b0; out_ready = 1'b1;
        #4; checks++;
        if (mb_data_in_valid !== 1'b0 || ch_data_ready !== 4'b0000 || out_valid !== 1'b1 ||
            out_id !== 2'd0 || out_data !== blk) begin
            errors++; $display("FAIL single_idle_out0: din_v=%b data_rdy=%b out_v=%b out_id=%0d required 0/0000/1/0",
                               mb_data_in_valid, ch_data_ready, out_valid, out_id);
        end
        next_cycle();
        mb_data_out_last = 1'b1;
        #4; checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_last !== 1'b1 || mb_data_out_ready !== 1'b1) begin
            errors++; $display("FAIL single_out1: out_v=%b out_id=%0d last=%b mb_rdy=%b required 1/0/1/1",
                               out_valid, out_id, out_last, mb_data_out_ready);
        end
        next_cycle();
        mb_data_out_valid = 1'b0; mb_data_out_last = 1'b0;
        #4; checks++;
        if (out_id !== 2'd0 || mb_data_out_ready !== 1'b0 || id_underflow !== 1'b0) begin
            errors++; $display("FAIL single_fifo_drained: out_id=%0d mb_rdy=%b uf=%b required 0/0/0",
                               out_id, mb_data_out_ready, id_underflow);
        end
        next_cycle();
    endtask

    // Traffic engine: channel sources, builder sink/source and round-robin scoreboard.
    task automatic run_traffic(input int n0, input int n1, input int n2, input int n3,
                               input int max_beats, input int stall, input int hold,
                               input int exp_hold, input int budget);
        int cur, rr, pred, accepted, cyc, nb, c;
        bit done, out_held, blk_last, lastb;
        logic [511:0] blk;
        logic [NUM_CH-1:0] cmask, dmask;
        pkts_left[0] = n0; pkts_left[1] = n1; pkts_left[2] = n2; pkts_left[3] = n3;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            head[ch] = 0; phase[ch] = 1'b0; dv_held[ch] = 1'b0; nb = 0;
            for (int p = 0; p < pkts_left[ch]; p++) begin
                int n;
                n = $urandom_range(1, max_beats);
                for (int b = 0; b < n; b++) begin
                    beat_mem[ch][nb] = rand512();
                    blast_mem[ch][nb] = (b == n - 1);
                    nb++;
                end
            end
        end
        id_q.delete(); grant_log.delete();
        cur = -1; rr = 0; accepted = 0; cyc = 0; done = 1'b0; out_held = 1'b0;
        blk = '0; blk_last = 1'b0;
        while (!done && cyc < budget) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                ch_cfg_valid[ch] = !phase[ch] && pkts_left[ch] > 0;
                ch_cfg_size[ch*64 +: 64] = 64'(ch * 256 + pkts_left[ch]);
                ch_cfg_scheme[ch*2 +: 2] = 2'(ch);
                ch_cfg_last[ch] = 1'b1;
                if (phase[ch] && !dv_held[ch]) dv_held[ch] = ($urandom_range(0, 99) >= stall);
                ch_data_valid[ch] = phase[ch] && dv_held[ch];
                ch_data[ch*512 +: 512] = phase[ch] ? beat_mem[ch][head[ch]] : '0;
                ch_data_last[ch] = phase[ch] ? blast_mem[ch][head[ch]] : 1'b0;
            end
            mb_cfg_ready = ($urandom_range(0, 99) >= stall);
            mb_data_in_ready = ($urandom_range(0, 99) >= stall);
            if (id_q.size() > 0 && !out_held) begin
                out_held = ($urandom_range(0, 99) >= stall);
                if (out_held) begin
                    blk = rand512();
                    blk_last = $urandom_range(0, 1);
                end
            end
            mb_data_out_valid = out_held; mb_data_out = blk; mb_data_out_last = blk_last;
            out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(0, 99) >= stall);
            #4;
            pred = -1;
            if (cur < 0)
                for (int k = NUM_CH - 1; k >= 0; k--)
                    if (!phase[(rr + k) % NUM_CH] && pkts_left[(rr + k) % NUM_CH] > 0) pred = (rr + k) % NUM_CH;
            cmask = (pred >= 0) ? (NUM_CH'(1) << pred) : '0;
            dmask = (cur >= 0) ? (NUM_CH'(1) << cur) : '0;
            checks++;
            if ((ch_cfg_ready & ~cmask) !== '0 || (ch_data_ready & ~dmask) !== '0) begin
                errors++; $display("FAIL ready_exclusive cyc=%0d: cfg_rdy=%b data_rdy=%b allowed %b/%b",
                                   cyc, ch_cfg_ready, ch_data_ready, cmask, dmask);
            end
            checks++;
            if (out_valid !== (mb_data_out_valid && id_q.size() > 0)) begin
                errors++; $display("FAIL out_valid cyc=%0d: got %b required %b", cyc, out_valid,
                                   mb_data_out_valid && id_q.size() > 0);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_id !== ID_W'(id_q[0]) || out_data !== blk || out_last !== blk_last) begin
                    errors++; $display("FAIL out_block cyc=%0d: out_id=%0d required %0d last=%b required %b",
                                       cyc, out_id, id_q[0], out_last, blk_last);
                end
                out_held = 1'b0;
                if (blk_last) void'(id_q.pop_front());
            end
            if (mb_data_in_valid && mb_data_in_ready) begin
                checks++;
                if (cur < 0) begin
                    errors++; $display("FAIL data_beat cyc=%0d: beat forwarded with no packet open", cyc);
                end else begin
                    c = cur;
                    if (mb_data_in !== beat_mem[c][head[c]] || mb_data_in_last !== blast_mem[c][head[c]] ||
                        ch_data_ready !== dmask) begin
                        errors++; $display("FAIL data_beat cyc=%0d ch=%0d: last=%b required %b rdy=%b required %b data_ok=%b",
                                           cyc, c, mb_data_in_last, blast_mem[c][head[c]], ch_data_ready,
                                           dmask, mb_data_in === beat_mem[c][head[c]]);
                    end
                    lastb = blast_mem[c][head[c]];
                    head[c]++; dv_held[c] = 1'b0;
                    if (lastb) begin
                        phase[c] = 1'b0; rr = (c + 1) % NUM_CH; cur = -1;
                    end
                end
            end
            if (mb_cfg_valid && mb_cfg_ready) begin
                checks++;
                if (pred < 0) begin
                    errors++; $display("FAIL cfg_grant cyc=%0d: cfg accepted with no channel expected", cyc);
                end else begin
                    if (ch_cfg_ready !== cmask || mb_cfg_size !== 64'(pred * 256 + pkts_left[pred]) ||
                        mb_cfg_scheme !== 2'(pred)) begin
                        errors++; $display("FAIL cfg_grant cyc=%0d: rdy=%b required %b size=%0d required %0d",
                                           cyc, ch_cfg_ready, cmask, mb_cfg_size, pred * 256 + pkts_left[pred]);
                    end
                    phase[pred] = 1'b1; pkts_left[pred]--; cur = pred;
                    id_q.push_back(pred); grant_log.push_back(pred); accepted++;
                end
            end
            if (hold > 0 && cyc == hold - 1) begin
                checks++;
                if (accepted !== exp_hold) begin
                    errors++; $display("FAIL fifo_full_block: cfgs accepted=%0d required %0d", accepted, exp_hold);
                end
            end
            done = (cur < 0) && (id_q.size() == 0) &&
                   (pkts_left[0] + pkts_left[1] + pkts_left[2] + pkts_left[3] == 0);
            cyc++;
            next_cycle();
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL traffic_timeout: finished=%b required 1 after %0d cycles", done, budget);
        end
        clear_inputs();
    endtask

    task automatic test_all_rr();
        int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        do_reset();
        run_traffic(2, 2, 2, 2, 1, 0, 0, 0, 400);
        checks++;
        if (grant_log.size() != 8 || grant_log[0] != exp_order[0] || grant_log[3] != exp_order[3] ||
            grant_log[4] != exp_order[4] || grant_log[7] != exp_order[7]) begin
            errors++; $display("FAIL rr_order: %0d grants logged, first=%0d required 8 grants 0,1,2,3,0,1,2,3",
                               grant_log.size(), grant_log.size() > 0 ? grant_log[0] : -1);
        end
    endtask

    task automatic test_fifo_full();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        bit ok;
        do_reset();
        run_traffic(2, 1, 1, 1, 1, 0, 60, 4, 400);
        ok = (grant_log.size() == 5);
        for (int i = 0; i < 5 && ok; i++) ok = (grant_log[i] == exp_order[i]);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL fifo_full_order: %0d grants logged, required order 0,1,2,3,0", grant_log.size());
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            do_reset();
            run_traffic($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 4),
                        $urandom_range(1, 4), 4, 40, 0, 0, 6000);
        end
    endtask

    task automatic test_en_sync_rst();
        logic [511:0] d1, d2a, d2b;
        d1 = rand512(); d2a = rand512(); d2b = rand512();
        do_reset();
        ch_cfg_valid = 4'b0110; ch_cfg_size[64 +: 64] = 64'd100; ch_cfg_size[128 +: 64] = 64'd200;
        ch_data_valid = 4'b0110; ch_data_last = 4'b0010;
        ch_data[512 +: 512] = d1; ch_data[1024 +: 512] = d2a;
        mb_cfg_ready = 1'b1; mb_data_in_ready = 1'b1;
        next_cycle(); next_cycle();
        ch_cfg_valid = 4'b0100;
        next_cycle();
        ch_data_valid = 4'b0100;
        next_cycle();
        #4; checks++;
        if (ch_cfg_ready !== 4'b0100 || mb_cfg_size !== 64'd200) begin
            errors++; $display("FAIL en_rr_next: cfg_rdy=%b size=%0d required 0100/200", ch_cfg_ready, mb_cfg_size);
        end
        next_cycle();
        ch_cfg_valid = '0;
        #4; checks++;
        if (mb_data_in_valid !== 1'b1 || mb_data_in !== d2a || ch_data_ready !== 4'b0100) begin
            errors++; $display("FAIL en_beat0: valid=%b rdy=%b required 1/0100", mb_data_in_valid, ch_data_ready);
        end
        next_cycle();
        en = 1'b0; ch_data[1024 +: 512] = d2b; ch_cfg_valid = '1;
        mb_data_out_valid = 1'b1; mb_data_out_last = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #4; checks++;
            if ({mb_cfg_valid, mb_data_in_valid, ch_cfg_ready, ch_data_ready, out_valid, mb_data_out_ready} !== '0) begin
                errors++; $display("FAIL en_low_quiet cyc=%0d: cfg_v=%b din_v=%b cfg_rdy=%b data_rdy=%b out_v=%b, all required 0",
                                   i, mb_cfg_valid, mb_data_in_valid, ch_cfg_ready, ch_data_ready, out_valid);
            end
            next_cycle();
        end
        en = 1'b1; ch_cfg_valid = '0;
        #4; checks++;
        if (mb_data_in_valid !== 1'b1 || mb_data_in !== d2b || ch_data_ready !== 4'b0100 ||
            out_valid !== 1'b1 || out_id !== 2'd1) begin
            errors++; $display("FAIL en_resume: din_v=%b rdy=%b out_v=%b out_id=%0d required 1/0100/1/1",
                               mb_data_in_valid, ch_data_ready, out_valid, out_id);
        end
        next_cycle();
        sync_rst = 1'b1; mb_data_out_valid = 1'b0;
        next_cycle();
        sync_rst = 1'b0; ch_cfg_valid = '1; ch_cfg_size[63:0] = 64'd77;
        #4; checks++;
        if ({mb_cfg_valid, mb_data_in_valid, ch_cfg_ready, ch_data_ready, out_valid, mb_data_out_ready,
             out_id, id_underflow} !== '0 || mb_cfg_size !== 64'd0 || mb_data_in !== 512'd0) begin
            errors++; $display("FAIL sync_rst_outputs: cfg_v=%b din_v=%b cfg_rdy=%b mb_rdy=%b out_id=%0d, all required 0",
                               mb_cfg_valid, mb_data_in_valid, ch_cfg_ready, mb_data_out_ready, out_id);
        end
        next_cycle();
        #4; checks++;
        if (ch_cfg_ready !== 4'b0001 || mb_cfg_size !== 64'd77) begin
            errors++; $display("FAIL sync_rst_grant: cfg_rdy=%b size=%0d required 0001/77", ch_cfg_ready, mb_cfg_size);
        end
        next_cycle();
        do_reset();
    endtask

    task automatic test_underflow();
        do_reset();
        mb_data_out_valid = 1'b1; mb_data_out_last = 1'b1; out_ready = 1'b1;
        #4; checks++;
        if (out_valid !== 1'b0 || mb_data_out_ready !== 1'b0 || id_underflow !== 1'b0) begin
            errors++; $display("FAIL underflow_gate: out_v=%b mb_rdy=%b uf=%b required 0/0/0",
                               out_valid, mb_data_out_ready, id_underflow);
        end
        next_cycle();
        mb_data_out_valid = 1'b0;
        repeat (3) next_cycle();
        #4; checks++;
        if (id_underflow !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL underflow_sticky: uf=%b out_v=%b required 1/0", id_underflow, out_valid);
        end
        rst = 1'b1;
        #1; checks++;
        if (id_underflow !== 1'b0) begin
            errors++; $display("FAIL underflow_clear: uf=%b required 0", id_underflow);
        end
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_rr();
        test_fifo_full();
        test_random();
        test_en_sync_rst();
        test_underflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
